// File: rtl/seq_pattern_pkg.sv
// Shared definitions for the serial pattern transmitter and its matching detector.
// Contents:
//   state_t      - transmitter FSM encoding (IDLE/SEND/GAP)
//   PAT_LEN_DEF  - default pattern length, shared with the detector
//   PATTERN_DEF  - default pattern value, MSB sent/detected first
//   cnt_width()  - clog2-based width of a bit-position counter
//   BIT_CNT_W    - bit-counter width for the default pattern
package seq_pattern_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    GAP  = 2'd2
  } state_t;

  localparam int unsigned PAT_LEN_DEF = 32'd7;
  localparam logic [PAT_LEN_DEF-1:0] PATTERN_DEF = 7'b1111001;

  // Width needed to hold bit positions 0..n-1; never less than one bit.
  function automatic int unsigned cnt_width(input int unsigned n);
    int unsigned w;
    w = $clog2(n);
    cnt_width = (w < 32'd1) ? 32'd1 : w;
  endfunction

  localparam int unsigned BIT_CNT_W = cnt_width(PAT_LEN_DEF);

endpackage

// File: rtl/seq_pattern_tx_pattern_shifter.sv
// pattern_shifter: loadable PAT_LEN-bit shift register for seq_pattern_tx.
// The register MSB is the bit currently on the line; pos_o is its index in PATTERN.
// Ports:
//   clk_i, rst_i   - clock, asynchronous active-high reset
//   burst_load_i   - new burst: latch (possibly corrupted) pattern and load it
//   frame_load_i   - next frame of the same burst: reload the latched pattern
//   shift_i        - advance to the next bit
//   err_inj_i      - invert one bit of the pattern for the whole burst
//   err_pos_i      - index of the inverted bit; out-of-range means no inversion
//   new_head_o     - first bit of the pattern a burst load would latch
//   head_o         - first bit of the latched burst pattern
//   next_o         - bit that follows the one currently on the line
//   pos_o          - index in PATTERN of the bit currently on the line
module pattern_shifter
  import seq_pattern_pkg::*;
#(
  parameter int unsigned        PAT_LEN = PAT_LEN_DEF,
  parameter logic [PAT_LEN-1:0] PATTERN = PATTERN_DEF
) (
  input  logic                            clk_i,
  input  logic                            rst_i,
  input  logic                            burst_load_i,
  input  logic                            frame_load_i,
  input  logic                            shift_i,
  input  logic                            err_inj_i,
  input  logic [cnt_width(PAT_LEN)-1:0]   err_pos_i,
  output logic                            new_head_o,
  output logic                            head_o,
  output logic                            next_o,
  output logic [cnt_width(PAT_LEN)-1:0]   pos_o
);

  localparam int unsigned BW = cnt_width(PAT_LEN);

  logic [PAT_LEN-1:0] pat_q, pat_d;
  logic [PAT_LEN-1:0] shreg_q, shreg_d;
  logic [BW-1:0]      pos_q, pos_d;
  logic [PAT_LEN-1:0] pat_new_s;

  // One-hot inversion mask; a shift past the top leaves it empty, so
  // err_pos >= PAT_LEN corrupts nothing.
  function automatic logic [PAT_LEN-1:0] err_mask(input logic inj, input logic [BW-1:0] pos);
    logic [PAT_LEN-1:0] one;
    one      = {{(PAT_LEN-1){1'b0}}, 1'b1};
    err_mask = (one << pos) & {PAT_LEN{inj}};
  endfunction

  // Next-state of the latched pattern, shift register and bit position.
  always_comb begin
    pat_new_s = PATTERN ^ err_mask(err_inj_i, err_pos_i);
    pat_d     = pat_q;
    shreg_d   = shreg_q;
    pos_d     = pos_q;
    if (burst_load_i) begin
      pat_d   = pat_new_s;
      shreg_d = pat_new_s;
      pos_d   = BW'(PAT_LEN - 1);
    end else if (frame_load_i) begin
      shreg_d = pat_q;
      pos_d   = BW'(PAT_LEN - 1);
    end else if (shift_i) begin
      shreg_d = {shreg_q[PAT_LEN-2:0], 1'b0};
      pos_d   = pos_q - BW'(1);
    end else begin
      shreg_d = shreg_q;
      pos_d   = pos_q;
    end
  end

  // Pattern, shift register and position registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      pat_q   <= {PAT_LEN{1'b0}};
      shreg_q <= {PAT_LEN{1'b0}};
      pos_q   <= {BW{1'b0}};
    end else begin
      pat_q   <= pat_d;
      shreg_q <= shreg_d;
      pos_q   <= pos_d;
    end
  end

  assign new_head_o = pat_new_s[PAT_LEN-1];
  assign head_o     = pat_q[PAT_LEN-1];
  assign next_o     = shreg_q[PAT_LEN-2];
  assign pos_o      = pos_q;

endmodule

// File: rtl/seq_pattern_tx.sv
// seq_pattern_tx: serial pattern transmitter feeding non-overlapping sequence
// detectors. Sends PATTERN MSB first, rep_cnt frames, gap_len idle zeros between.
// Optional feature: define SEQ_TX_ERR_INJECT_EN to add err_inj/err_pos, which
// invert one pattern bit in every frame of a burst.
// Ports:
//   clk, rst   - clock, asynchronous active-high reset
//   start      - burst request, accepted only while busy=0
//   rep_cnt    - frames per burst (0 behaves as 1), latched on accept
//   gap_len    - idle-zero cycles between frames, latched on accept
//   abort      - synchronous cancel of an active burst (no done pulse)
//   x_out      - serial data bit (registered)
//   x_vld      - x_out carries a pattern bit (registered)
//   busy       - burst in progress (registered)
//   done       - one-cycle pulse after the last bit of a completed burst
//   frame_idx  - 0-based index of the frame being sent
module seq_pattern_tx
  import seq_pattern_pkg::*;
#(
  parameter int unsigned        PAT_LEN = PAT_LEN_DEF,
  parameter logic [PAT_LEN-1:0] PATTERN = PATTERN_DEF,
  parameter int unsigned        REP_W   = 32'd4,
  parameter int unsigned        GAP_W   = 32'd4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  input  logic [REP_W-1:0]              rep_cnt,
  input  logic [GAP_W-1:0]              gap_len,
  input  logic                          abort,
`ifdef SEQ_TX_ERR_INJECT_EN
  input  logic                          err_inj,
  input  logic [cnt_width(PAT_LEN)-1:0] err_pos,
`endif
  output logic                          x_out,
  output logic                          x_vld,
  output logic                          busy,
  output logic                          done,
  output logic [REP_W-1:0]              frame_idx
);

  localparam int unsigned BW = cnt_width(PAT_LEN);

  state_t             state_q, state_d;
  logic [REP_W-1:0]   rep_q, rep_d;
  logic [GAP_W-1:0]   gap_q, gap_d;
  logic [GAP_W-1:0]   gap_cnt_q, gap_cnt_d;
  logic [REP_W-1:0]   frame_q, frame_d;
  logic               x_out_q, x_out_d;
  logic               x_vld_q, x_vld_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  logic               burst_load_s, frame_load_s, shift_s;
  logic               new_head_s, head_s, next_bit_s;
  logic [BW-1:0]      pos_s;
  logic               err_inj_s;
  logic [BW-1:0]      err_pos_s;
  logic               more_frames_s;

`ifdef SEQ_TX_ERR_INJECT_EN
  assign err_inj_s = err_inj;
  assign err_pos_s = err_pos;
`else
  assign err_inj_s = 1'b0;
  assign err_pos_s = {BW{1'b0}};
`endif

  pattern_shifter #(
    .PAT_LEN (PAT_LEN),
    .PATTERN (PATTERN)
  ) u_shifter (
    .clk_i        (clk),
    .rst_i        (rst),
    .burst_load_i (burst_load_s),
    .frame_load_i (frame_load_s),
    .shift_i      (shift_s),
    .err_inj_i    (err_inj_s),
    .err_pos_i    (err_pos_s),
    .new_head_o   (new_head_s),
    .head_o       (head_s),
    .next_o       (next_bit_s),
    .pos_o        (pos_s)
  );

  // frame_q never exceeds rep_q-1, so the increment cannot overflow.
  assign more_frames_s = (frame_q + REP_W'(1)) < rep_q;

  // Next-state and next-output logic; outputs are computed one cycle ahead.
  always_comb begin
    state_d      = state_q;
    rep_d        = rep_q;
    gap_d        = gap_q;
    gap_cnt_d    = gap_cnt_q;
    frame_d      = frame_q;
    x_out_d      = 1'b0;
    x_vld_d      = 1'b0;
    busy_d       = 1'b0;
    done_d       = 1'b0;
    burst_load_s = 1'b0;
    frame_load_s = 1'b0;
    shift_s      = 1'b0;
    case (state_q)
      IDLE: begin
        // abort beats a simultaneous start
        if (start && !abort) begin
          burst_load_s = 1'b1;
          rep_d        = (rep_cnt == {REP_W{1'b0}}) ? REP_W'(1) : rep_cnt;
          gap_d        = gap_len;
          frame_d      = {REP_W{1'b0}};
          state_d      = SEND;
          x_out_d      = new_head_s;
          x_vld_d      = 1'b1;
          busy_d       = 1'b1;
        end else begin
          state_d = IDLE;
          frame_d = {REP_W{1'b0}};
        end
      end
      SEND: begin
        if (abort) begin
          state_d = IDLE;
          frame_d = {REP_W{1'b0}};
        end else if (pos_s != {BW{1'b0}}) begin
          shift_s = 1'b1;
          x_out_d = next_bit_s;
          x_vld_d = 1'b1;
          busy_d  = 1'b1;
        end else if (!more_frames_s) begin
          state_d = IDLE;
          frame_d = {REP_W{1'b0}};
          done_d  = 1'b1;
        end else if (gap_q != {GAP_W{1'b0}}) begin
          // gap_cnt runs gap-1 .. 0, giving exactly gap idle cycles
          state_d   = GAP;
          gap_cnt_d = gap_q - GAP_W'(1);
          busy_d    = 1'b1;
        end else begin
          frame_load_s = 1'b1;
          frame_d      = frame_q + REP_W'(1);
          x_out_d      = head_s;
          x_vld_d      = 1'b1;
          busy_d       = 1'b1;
        end
      end
      GAP: begin
        if (abort) begin
          state_d = IDLE;
          frame_d = {REP_W{1'b0}};
        end else if (gap_cnt_q != {GAP_W{1'b0}}) begin
          gap_cnt_d = gap_cnt_q - GAP_W'(1);
          busy_d    = 1'b1;
        end else begin
          state_d      = SEND;
          frame_load_s = 1'b1;
          frame_d      = frame_q + REP_W'(1);
          x_out_d      = head_s;
          x_vld_d      = 1'b1;
          busy_d       = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        frame_d = {REP_W{1'b0}};
      end
    endcase
  end

  // State, burst configuration, counters and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      rep_q     <= {REP_W{1'b0}};
      gap_q     <= {GAP_W{1'b0}};
      gap_cnt_q <= {GAP_W{1'b0}};
      frame_q   <= {REP_W{1'b0}};
      x_out_q   <= 1'b0;
      x_vld_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      rep_q     <= rep_d;
      gap_q     <= gap_d;
      gap_cnt_q <= gap_cnt_d;
      frame_q   <= frame_d;
      x_out_q   <= x_out_d;
      x_vld_q   <= x_vld_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign x_out     = x_out_q;
  assign x_vld     = x_vld_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign frame_idx = frame_q;

endmodule

// File: doc/seq_pattern_tx.md
Name: seq_pattern_tx

Overview:
- Serial pattern transmitter: the transmit-side counterpart of the team's Mealy non-overlapping sequence detectors.
- On a start request it emits a fixed N-bit pattern (default 1111001), MSB first, one bit per clock.
- The pattern is repeated a programmable number of frames, with a programmable run of idle zeros between frames.
- Drives detector inputs in system and bench stimulus; the x_out of this block connects directly to a detector's x.

Parameters:
- PAT_LEN, 7, pattern length in bits (2..32).
- PATTERN, 7'b1111001, pattern value (PAT_LEN bits); bit PAT_LEN-1 is sent first.
- REP_W, 4, width of the repeat-count input.
- GAP_W, 4, width of the gap-length input.

Ports:
- clk  in  1  clock, all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  request; accepted only in a cycle with busy=0.
- rep_cnt  in  REP_W  frames to send; sampled on accept; 0 treated as 1.
- gap_len  in  GAP_W  idle-zero cycles between frames; sampled on accept.
- abort  in  1  synchronous cancel of an active burst.
- x_out  out  1  serial data bit.
- x_vld  out  1  high while x_out carries a pattern bit.
- busy  out  1  burst in progress.
- done  out  1  one-cycle pulse after the last bit of a completed burst.
- frame_idx  out  REP_W  index of the frame currently being sent (0-based).

Behaviour:
- All outputs are registered. Reset (any time, including mid-burst): state IDLE; x_out=0, x_vld=0, busy=0, done=0, frame_idx=0; latched rep/gap cleared.
- States:
  - IDLE: x_out=0, x_vld=0.
  - SEND: bit counter b counts PAT_LEN-1 down to 0; x_out=PATTERN[b], x_vld=1.
  - GAP: gap counter counts down; x_out=0, x_vld=0.
- Accept: start=1 and busy=0 at edge k.
  - After edge k: SEND, busy=1, x_out=PATTERN[PAT_LEN-1].
  - Each following edge advances one bit; the last bit is present after edge k+PAT_LEN-1. Latency from accept to first bit: 1 cycle.
- End of frame (edge with b=0 in SEND):
  - Frames remain and gap_len>0: go to GAP for exactly gap_len cycles, then SEND with the first bit; frame_idx increments on entering the next SEND.
  - Frames remain and gap_len=0: next frame's first bit immediately, back-to-back; frame_idx increments.
  - Last frame: go to IDLE; busy=0 and done=1 for exactly one cycle; frame_idx returns to 0.
- A burst of R frames with gap G keeps busy high for R*PAT_LEN + (R-1)*G cycles.
- start while busy=1: ignored, with no queueing. start in the done cycle (busy=0): accepted; the next burst begins on the following cycle.
- rep_cnt and gap_len changes after accept have no effect on the active burst.
- abort=1 at an edge while busy: return to IDLE; x_out=0, x_vld=0, busy=0, done=0 (no done pulse); frame_idx=0.
- abort in IDLE: no effect. abort and start together in IDLE: abort wins and start is dropped.
- Counters never wrap:
  - The bit counter reloads to PAT_LEN-1 at each frame start.
  - The frame counter saturates at the latched rep_cnt.

Optional Feature:
- SEQ_TX_ERR_INJECT_EN defined:
  - Adds inputs err_inj (1) and err_pos (clog2(PAT_LEN)), both sampled on accept.
  - If err_inj=1, the bit at pattern position err_pos (same index as PATTERN) is inverted in every frame of that burst; x_vld is unchanged.
  - err_pos >= PAT_LEN: no bit is inverted.
  - Used to prove that detectors reject corrupted frames.
- Not defined: the ports are absent and the pattern is always sent unmodified.

Decomposition:
- Shared package seq_pattern_pkg:
  - state encoding constants IDLE/SEND/GAP;
  - default PATTERN and PAT_LEN constants, shared with the matching detector;
  - a clog2-based width constant for the bit counter.
- One sub-module, pattern_shifter:
  - loadable PAT_LEN-bit shift register with bit-position output;
  - handles load at frame start and error-bit inversion.
- The top level holds the FSM, gap/frame counters and handshake.

Test Plan:
- Reset then start with rep_cnt=1, gap_len=0 -> x_out=1,1,1,1,0,0,1 on cycles 1..7 after accept, x_vld=1 throughout; done=1 on cycle 8 only; busy high for exactly 7 cycles.
- rep_cnt=3, gap_len=2, driving a non-overlapping 1111001 detector -> busy high 25 cycles; two 0/x_vld=0 cycles between frames; detector z pulses exactly 3 times; frame_idx steps 0,1,2.
- rep_cnt=0, gap_len=5 -> identical to a single frame; no GAP state entered.
- abort asserted on cycle 4 of frame 2 (rep_cnt=4) -> IDLE next cycle, x_out=0, no done pulse; a fresh start the following cycle is accepted normally.
- start held high across a burst and reasserted in the done cycle -> the second burst starts the cycle after done; starts during busy are ignored. Async rst mid-frame clears all outputs immediately.
- With SEQ_TX_ERR_INJECT_EN defined, err_inj=1, err_pos=2 -> frames read 1111101; detector z never asserts; x_vld pattern is unchanged.
